freq_meter: RTL
===============

Name: freq_meter

Overview:
- Gated-window frequency counter; the measuring end of the clock-divider chain.
- Counts rising edges of an asynchronous input `sig_in` over a fixed window of `GATE_CYCLES` CP periods. Publishes the count as a frequency word with a one-cycle valid strobe.
- Used to check divider outputs (e.g. the 1 Hz tick) and external signals on the board; feeds the display path.

Parameters:
- GATE_CYCLES, 50_000_000, window length in CP cycles (1 s at 50 MHz); must be > CNT_W+2.
- CNT_W, 26, width of the edge counter and result word.
- BCD_DIGITS, 8, BCD digits produced when FREQ_BCD_EN is defined.

Ports:
- CP  input  1  system clock.
- nCR  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal under measurement.
- freq  output  CNT_W  last completed measurement, edges per window.
- freq_valid  output  1  one-cycle pulse when freq updates.
- ovf  output  1  last window saturated the counter.
- bcd  output  4*BCD_DIGITS  BCD of freq (only with FREQ_BCD_EN).
- bcd_valid  output  1  one-cycle pulse when bcd updates (only with FREQ_BCD_EN).

Behaviour:
- Reset: nCR low asynchronously clears every register. freq=0, freq_valid=0, ovf=0, bcd=0, bcd_valid=0, FSM=S_FIRST.
- Input path: 2-FF synchronizer s1,s2, then s3; edge = s2 & ~s3.
  - A sig_in rise is counted 3 CP cycles later.
  - Measurable maximum is GATE_CYCLES/2 (sig_in period ≥ 2 CP with each level ≥ 1 CP).
- Gate counter gcnt runs 0..GATE_CYCLES-1 and wraps to 0 at the end of each window.
- Edge counter ecnt increments on edge. It saturates at 2^CNT_W-1 and never wraps; a sticky sat flag is set on saturation.
- End of window (gcnt==GATE_CYCLES-1):
  - Captured value is ecnt+edge, saturating, so an edge in the last cycle counts.
  - ecnt is cleared to 0 and sat is cleared for the next window.
  - An edge on the cycle after the boundary counts toward the new window.
- FSM:
  - S_FIRST: first window after reset. At window end, the count is discarded (synchronizer warm-up), no freq_valid; go to S_GATE.
  - S_GATE: at every window end, freq and ovf are registered, and freq_valid is high for exactly the next cycle. Stay in S_GATE.
- Window timing:
  - First freq_valid occurs 2*GATE_CYCLES cycles after reset release.
  - Subsequent pulses occur every GATE_CYCLES cycles.
- Constant sig_in: freq=0 and ovf=0 each window.
- freq and ovf hold between pulses.
- Reset mid-window: everything restarts from S_FIRST; no partial result is ever published.

Optional Feature:
- Macro FREQ_BCD_EN.
- Defined:
  - A sequential shift-add-3 (double-dabble) converter starts on freq_valid using the freshly latched freq.
  - It takes CNT_W cycles, then loads bcd and pulses bcd_valid for 1 cycle, CNT_W+1 cycles after freq_valid.
  - Gating never stalls. Conversion finishes before the next window because GATE_CYCLES > CNT_W+2.
  - Values ≥ 10^BCD_DIGITS are not expected at default sizes; excess digits are truncated.
- Not defined: bcd and bcd_valid ports and all converter logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package freq_meter_pkg holds:
  - FSM state encoding (S_FIRST, S_GATE).
  - The default CP frequency constant (50_000_000).
  - The BCD nibble width constant (4).
- One sub-module, bin2bcd_seq: start/busy/done sequential double-dabble, parameterised by CNT_W and BCD_DIGITS. It is instantiated only under FREQ_BCD_EN.

Test Plan (GATE_CYCLES=100, CNT_W=8 unless noted):
- sig_in period 10 CP (5 high/5 low) -> no pulse at cycle ~100; freq_valid pulses at ~200, 300, ... with freq=10, ovf=0.
- sig_in period 2 CP -> freq=50, ovf=0 every window; freq_valid exactly 1 cycle wide.
- sig_in held 1 -> freq=0 each window; hold 0 for a window then toggle once -> freq=1 for that window.
- CNT_W=4, sig_in period 2 -> freq=15, ovf=1. Then slow sig_in to period 20 -> next window freq=5, ovf=0.
- Assert nCR at cycle 250 (mid-window), release at 260 -> outputs 0 immediately; next freq_valid at 260+200; no stale value published.
- FREQ_BCD_EN, CNT_W=8, sig_in period 4 -> freq=25; bcd=0x00000025 and bcd_valid 9 cycles after freq_valid.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared constants for the gated-window frequency meter.
package freq_meter_pkg;
    localparam logic [0:0] S_FIRST = 1'b0;
    localparam logic [0:0] S_GATE  = 1'b1;
    localparam int CP_HZ = 50_000_000;
    localparam int NIB_W = 4;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int CNT_W      = 26,
    parameter int BCD_DIGITS = 8
) (
    input  logic                          CP,
    input  logic                          nCR,
    input  logic                          start,
    input  logic [CNT_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [NIB_W*BCD_DIGITS-1:0]   bcd
);
    localparam int BW  = NIB_W * BCD_DIGITS;
    localparam int C_W = $clog2(CNT_W + 1);
    logic [CNT_W-1:0] sh;
    logic [BW-1:0]    acc, adj, nxt;
    logic [C_W-1:0]   cnt;
    logic             last;
    assign last = busy && cnt == C_W'(1);
    always_comb begin
        adj = acc;
        for (int i = 0; i < BCD_DIGITS; i++)
            adj[i*NIB_W +: NIB_W] = (acc[i*NIB_W +: NIB_W] >= 4'd5) ? acc[i*NIB_W +: NIB_W] + 4'd3 : acc[i*NIB_W +: NIB_W];
        // digits shifted past the top are dropped
        nxt = BW'({adj, sh[CNT_W-1]});
    end
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= last;
            if (last) bcd <= nxt;
            if (start) begin
                sh   <= bin;
                acc  <= '0;
                cnt  <= C_W'(CNT_W);
                busy <= 1'b1;
            end else if (busy) begin
                sh   <= sh << 1;
                acc  <= nxt;
                cnt  <= cnt - C_W'(1);
                busy <= !last;
            end
        end
    end
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over GATE_CYCLES CP periods and publishes the count.
// Define FREQ_BCD_EN to add the bcd/bcd_valid outputs and the BCD converter.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = CP_HZ,
    parameter int CNT_W       = 26,
    parameter int BCD_DIGITS  = 8
) (
    input  logic                        CP,
    input  logic                        nCR,
    input  logic                        sig_in,
    output logic [CNT_W-1:0]            freq,
    output logic                        freq_valid,
    output logic                        ovf
`ifdef FREQ_BCD_EN
    ,
    output logic [NIB_W*BCD_DIGITS-1:0] bcd,
    output logic                        bcd_valid
`endif
);
    localparam int G_W = $clog2(GATE_CYCLES);
    localparam logic [CNT_W-1:0] MAX = '1;
    if (GATE_CYCLES <= CNT_W + 2 || BCD_DIGITS < 1) begin : g_cfg_err
        $error("freq_meter: GATE_CYCLES must exceed CNT_W+2 and BCD_DIGITS must be positive");
    end
    logic             s1, s2, s3, rise, full, lost, win_end;
    logic [0:0]       state;
    logic [G_W-1:0]   gcnt;
    logic [CNT_W-1:0] ecnt, ecnt_nxt;
    logic             sat;
    assign rise     = s2 & ~s3;
    assign full     = ecnt == MAX;
    // ovf means at least one edge was lost, not merely that the top value was reached
    assign lost     = rise & full;
    assign ecnt_nxt = ecnt + CNT_W'(rise & ~full);
    assign win_end  = gcnt == G_W'(GATE_CYCLES - 1);
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            {s3, s2, s1} <= 3'b000;
            state        <= S_FIRST;
            gcnt         <= '0;
            ecnt         <= '0;
            sat          <= 1'b0;
            freq         <= '0;
            ovf          <= 1'b0;
            freq_valid   <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, sig_in};
            freq_valid   <= 1'b0;
            if (win_end) begin
                gcnt  <= '0;
                ecnt  <= '0;
                sat   <= 1'b0;
                state <= S_GATE;
                // the first window only warms up the synchronizer
                if (state == S_GATE) begin
                    freq       <= ecnt_nxt;
                    ovf        <= sat | lost;
                    freq_valid <= 1'b1;
                end
            end else begin
                gcnt <= gcnt + G_W'(1);
                ecnt <= ecnt_nxt;
                sat  <= sat | lost;
            end
        end
    end
`ifdef FREQ_BCD_EN
    logic bcd_busy;
    bin2bcd_seq #(.CNT_W(CNT_W), .BCD_DIGITS(BCD_DIGITS)) u_bcd (
        .CP    (CP),
        .nCR   (nCR),
        .start (freq_valid & ~bcd_busy),
        .bin   (freq),
        .busy  (bcd_busy),
        .done  (bcd_valid),
        .bcd   (bcd)
    );
`endif
endmodule
